// File: rtl/chan_sel_mux.sv
// N-channel registered selector with valid/ready flow control, deferred select switching
// and a one-entry output pipe. Define SEL_ERR_CNT_EN to add the saturating err_cnt output.
module chan_sel_mux #(
    parameter int  NCH  = 4,
    parameter int  W    = 8,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*W-1:0]     in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 sel_vld,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      cur_sel,
    output logic                 sel_err,
    output logic                 busy
`ifdef SEL_ERR_CNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

    state_t               state_q;
    logic [SELW-1:0]      cur_sel_q;
    logic [SELW-1:0]      pend_sel_q;
    logic [W-1:0]         out_data_q;
    logic                 out_valid_q;
    logic                 sel_err_q;

    logic [NCH-1:0][W-1:0] ch_data;
    logic                 sel_in_range;
    logic                 sel_ok_d;
    logic                 sel_bad_d;
    logic                 ready_cur_d;
    logic                 load_d;
    logic                 drain_d;

    assign ch_data = in_data;

    // Comparison is one bit wider than sel so it stays meaningful when NCH is a power of 2.
    assign sel_in_range = ({1'b0, sel} < NCH_L);
    assign sel_ok_d     = sel_vld & sel_in_range;
    assign sel_bad_d    = sel_vld & ~sel_in_range;

    assign ready_cur_d  = (state_q == PASS) & (~out_valid_q | out_ready);
    assign load_d       = ready_cur_d & in_valid[cur_sel_q];
    assign drain_d      = out_valid_q & out_ready & ~load_d;

    // NOTE: every output of a combinational block is given a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        in_ready = '0;
        if (ready_cur_d) begin
            in_ready[cur_sel_q] = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_sel_q   <= '0;
            pend_sel_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            sel_err_q <= sel_bad_d;

            unique case (state_q)
                IDLE: begin
                    if (sel_ok_d) begin
                        cur_sel_q <= sel;
                        state_q   <= PASS;
                    end
                end
                PASS: begin
                    if (sel_ok_d) begin
                        pend_sel_q <= sel;
                        state_q    <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (sel_ok_d) begin
                        pend_sel_q <= sel;
                    end
                    // A request arriving on the switching edge itself is the latest one.
                    if (!out_valid_q) begin
                        cur_sel_q <= sel_ok_d ? sel : pend_sel_q;
                        state_q   <= PASS;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (load_d) begin
                out_data_q  <= ch_data[cur_sel_q];
                out_valid_q <= 1'b1;
            end else if (drain_d) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef SEL_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (sel_bad_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Without the counter, sel_err is the only record of a rejected select.
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;
    assign busy      = (state_q != PASS);

endmodule
